// File: rtl/router_sync.sv
// router_sync: address latch, write steering, valid-out and FIFO timeout flush for the 1x3 router.
// Ports: clock/reset; detect_add, data_in, write_enb_reg from the FSM; read_enb_x, empty_x, full_x
// from destinations/FIFOs; write_enb, fifo_full, vld_out_x, soft_reset_x out.
// Optional macro ROUTER_SYNC_TIMEOUT_STATUS_EN adds status_clr in / timeout_status[2:0] out
// (sticky per-port timeout flags).
module router_sync #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2
`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
  ,
  input  logic       status_clr,
  output logic [2:0] timeout_status
`endif
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       r_addr;
  logic [CNT_W-1:0] r_cnt [3];
  logic [2:0]       r_sr;
  logic [2:0]       w_vld;
  logic [2:0]       w_rd;
  logic [2:0]       w_qual;
  logic [2:0]       w_hit;

  assign w_vld = ~{empty_2, empty_1, empty_0};
  assign w_rd  = {read_enb_2, read_enb_1, read_enb_0};
  // data waiting and nobody reading it this cycle
  assign w_qual = w_vld & ~w_rd;

  assign vld_out_0 = w_vld[0];
  assign vld_out_1 = w_vld[1];
  assign vld_out_2 = w_vld[2];

  assign soft_reset_0 = r_sr[0];
  assign soft_reset_1 = r_sr[1];
  assign soft_reset_2 = r_sr[2];

  always_comb begin
    w_hit = 3'b000;
    for (int i = 0; i < 3; i++)
      w_hit[i] = w_qual[i] && (r_cnt[i] == C_LAST);
  end

  // steering uses the registered address, so a header
  // written in the same cycle still goes to the old port
  always_comb begin
    write_enb = 3'b000;
    fifo_full = 1'b0;
    case (r_addr)
      2'b00: begin
        write_enb = {2'b00, write_enb_reg};
        fifo_full = full_0;
      end
      2'b01: begin
        write_enb = {1'b0, write_enb_reg, 1'b0};
        fifo_full = full_1;
      end
      2'b10: begin
        write_enb = {write_enb_reg, 2'b00};
        fifo_full = full_2;
      end
      default: begin
        write_enb = 3'b000;
        fifo_full = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr <= 2'b11;
      r_sr   <= 3'b000;
      for (int i = 0; i < 3; i++)
        r_cnt[i] <= '0;
    end else begin
      if (detect_add)
        r_addr <= data_in;
      for (int i = 0; i < 3; i++) begin
        if (w_hit[i]) begin
          r_cnt[i] <= '0;
          r_sr[i]  <= 1'b1;
        end else if (w_qual[i]) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          r_sr[i]  <= 1'b0;
        end else begin
          r_cnt[i] <= '0;
          r_sr[i]  <= 1'b0;
        end
      end
    end
  end

`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
  logic [2:0] r_status;

  assign timeout_status = r_status;

  // a new timeout beats a simultaneous clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_status <= 3'b000;
    else if (status_clr)
      r_status <= w_hit;
    else
      r_status <= r_status | w_hit;
  end
`endif

endmodule

// File: tb/tb_router_sync.sv
// tb_router_sync: directed self-checking bench for router_sync.
// Drives inputs #1 after the rising edge and samples before the next one.
module tb_router_sync;

  logic       clock = 1'b0;
  logic       reset;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       empty_0, empty_1, empty_2;
  logic       full_0, full_1, full_2;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       status_clr;
  logic [2:0] timeout_status;

  int n_cmp = 0;
  int n_bad = 0;

  router_sync #(.TIMEOUT(30), .CNT_W(5)) dut (
    .clock(clock),
    .reset(reset),
    .detect_add(detect_add),
    .data_in(data_in),
    .write_enb_reg(write_enb_reg),
    .read_enb_0(read_enb_0),
    .read_enb_1(read_enb_1),
    .read_enb_2(read_enb_2),
    .empty_0(empty_0),
    .empty_1(empty_1),
    .empty_2(empty_2),
    .full_0(full_0),
    .full_1(full_1),
    .full_2(full_2),
    .write_enb(write_enb),
    .fifo_full(fifo_full),
    .vld_out_0(vld_out_0),
    .vld_out_1(vld_out_1),
    .vld_out_2(vld_out_2),
    .soft_reset_0(soft_reset_0),
    .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2)
`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
    ,
    .status_clr(status_clr),
    .timeout_status(timeout_status)
`endif
  );

`ifndef ROUTER_SYNC_TIMEOUT_STATUS_EN
  assign timeout_status = 3'b000;
`endif

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [2:0] sr();
    return {soft_reset_2, soft_reset_1, soft_reset_0};
  endfunction

  initial begin
    reset = 1'b1;
    detect_add = 0; data_in = 0; write_enb_reg = 0;
    read_enb_0 = 1; read_enb_1 = 1; read_enb_2 = 1;
    empty_0 = 1; empty_1 = 1; empty_2 = 1;
    full_0 = 0; full_1 = 0; full_2 = 0;
    status_clr = 0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // idle after reset
    chk("rst_wen", 32'(write_enb), 32'h0);
    chk("rst_full", 32'(fifo_full), 32'h0);
    chk("rst_sr", 32'(sr()), 32'h0);
    chk("rst_vld", 32'({vld_out_2, vld_out_1, vld_out_0}), 32'h0);
    chk("rst_stat", 32'(timeout_status), 32'h0);
    empty_1 = 0; #1;
    chk("vld1", 32'({vld_out_2, vld_out_1, vld_out_0}), 32'h2);
    empty_1 = 1; #1;

    // address 01 then write
    detect_add = 1; data_in = 2'b01;
    tick();
    detect_add = 0; write_enb_reg = 1; #1;
    chk("wen01", 32'(write_enb), 32'h2);
    full_1 = 1; #1;
    chk("full1", 32'(fifo_full), 32'h1);
    full_1 = 0; full_0 = 1; full_2 = 1; #1;
    chk("full02_ign", 32'(fifo_full), 32'h0);
    full_0 = 0; full_2 = 0; full_1 = 1; write_enb_reg = 0; #1;
    chk("wen_off", 32'(write_enb), 32'h0);
    chk("full_nowr", 32'(fifo_full), 32'h1);
    full_1 = 0;

    // same-cycle header and write: old address this cycle
    detect_add = 1; data_in = 2'b00;
    tick();
    data_in = 2'b10; write_enb_reg = 1; #1;
    chk("wen_old", 32'(write_enb), 32'h1);
    tick();
    detect_add = 0; #1;
    chk("wen_new", 32'(write_enb), 32'h4);
    full_2 = 1; #1;
    chk("full2", 32'(fifo_full), 32'h1);

    // invalid address 11
    detect_add = 1; data_in = 2'b11;
    tick();
    detect_add = 0; full_0 = 1; full_1 = 1; full_2 = 1; #1;
    chk("wen11", 32'(write_enb), 32'h0);
    chk("full11", 32'(fifo_full), 32'h0);
    full_0 = 0; full_1 = 0; full_2 = 0;

    // asynchronous reset mid-operation
    detect_add = 1; data_in = 2'b01;
    tick();
    detect_add = 0; full_1 = 1; #1;
    chk("pre_rst", 32'(write_enb), 32'h2);
    #2 reset = 1'b1; #1;
    chk("arst_wen", 32'(write_enb), 32'h0);
    chk("arst_full", 32'(fifo_full), 32'h0);
    tick();
    reset = 1'b0; write_enb_reg = 0; full_1 = 0;
    tick();

    // port 0 timeout: pulse after edge 30 and edge 60
    empty_0 = 0; read_enb_0 = 0;
    for (int k = 1; k <= 61; k++) begin
      tick();
      if (k == 30 || k == 60)
        chk($sformatf("p0_e%0d", k), 32'(sr()), 32'h1);
      else if (k == 29 || k == 31 || k == 59 || k == 61)
        chk($sformatf("p0_e%0d", k), 32'(sr()), 32'h0);
    end
`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
    chk("stat0", 32'(timeout_status), 32'h1);
    status_clr = 1;
    tick();
    status_clr = 0;
    chk("stat_clr", 32'(timeout_status), 32'h0);
`endif
    empty_0 = 1; read_enb_0 = 1;
    tick();

    // port 2: one read at edge 29 restarts the count
    empty_2 = 0; read_enb_2 = 0;
    for (int k = 1; k <= 60; k++) begin
      read_enb_2 = (k == 29);
      tick();
      if (k == 30 || k == 58 || k == 60)
        chk($sformatf("p2_e%0d", k), 32'(sr()), 32'h0);
      else if (k == 59)
        chk($sformatf("p2_e%0d", k), 32'(sr()), 32'h4);
    end
    chk("p2_vld", 32'({vld_out_2, vld_out_1, vld_out_0}), 32'h4);
    empty_2 = 1; read_enb_2 = 1;
    tick();

    // all three ports time out together
    empty_0 = 0; empty_1 = 0; empty_2 = 0;
    read_enb_0 = 0; read_enb_1 = 0; read_enb_2 = 0;
    for (int k = 1; k <= 30; k++) tick();
    chk("all_sr", 32'(sr()), 32'h7);
    tick();
    chk("all_sr_off", 32'(sr()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
